fpadd_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754 floating-point adder/subtractor; next generation of the single-precision fpadd_single.
- Configurable exponent/mantissa width, per-operation add/sub select, round-to-nearest-even, status flags.
- Valid/ready handshake with full-pipeline stall.
- Sits in the FPU datapath between the operand register file and the result writeback.

---
 rtl/fpadd_pipe_if.sv | 30 +++
 rtl/fpadd_pipe.sv | 189 ++++++++++++++++++
 tb/tb_fpadd_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpadd_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP adder.
// The master drives operands and out_ready; the slave (adder) returns results and flags.
interface fpadd_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] reg_A;
  logic [W-1:0] reg_B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         flag_ovf;
  logic         flag_inv;
  logic         flag_zero;

  modport master (
    output in_valid, op_sub, reg_A, reg_B, out_ready,
    input  in_ready, out_valid, out, flag_ovf, flag_inv, flag_zero
  );

  modport slave (
    input  in_valid, op_sub, reg_A, reg_B, out_ready,
    output in_ready, out_valid, out, flag_ovf, flag_inv, flag_zero
  );
endinterface

// File: rtl/fpadd_pipe.sv
// Pipelined IEEE-754 add/sub (RNE, denormals flushed), 3-cycle latency, 1 op/cycle.
// Whole pipeline freezes while a result sits unaccepted at the output (in_ready low).
module fpadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic        clk,
  input  logic        reset,
  fpadd_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;  // hidden, fraction, guard, round, sticky
  localparam int EW = EXP_W + 2;  // signed exponent with underflow headroom
  localparam logic [EXP_W-1:0]        EXP_MAX = '1;
  localparam logic signed [EW-1:0]    E_INF   = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]            QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance, take;
  assign advance      = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = advance;
  assign take         = bus.in_valid && advance;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic               sa, sb, sl, ss, swap;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [EXP_W-1:0]   ea, eb, el, es, diff;
  logic [MAN_W-1:0]   fa, fb;
  logic [W-2:0]       mag_a, mag_b;
  logic [MAN_W:0]     siga, sigb, sigl, sigs;
  logic [2*SW-1:0]    shifted;
  logic [SW-1:0]      aligned;
  int                 shamt;
  logic               s1_spec, s1_inv;
  logic [W-1:0]       s1_word;

  always_comb begin
    sa     = bus.reg_A[W-1];
    sb     = bus.reg_B[W-1] ^ bus.op_sub;
    ea     = bus.reg_A[W-2 -: EXP_W];
    eb     = bus.reg_B[W-2 -: EXP_W];
    fa     = bus.reg_A[MAN_W-1:0];
    fb     = bus.reg_B[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_MAX) && (fa == '0);
    b_inf  = (eb == EXP_MAX) && (fb == '0);
    a_nan  = (ea == EXP_MAX) && (fa != '0);
    b_nan  = (eb == EXP_MAX) && (fb != '0);
    siga   = a_zero ? '0 : {1'b1, fa};
    sigb   = b_zero ? '0 : {1'b1, fb};
    mag_a  = a_zero ? '0 : {ea, fa};
    mag_b  = b_zero ? '0 : {eb, fb};
    swap   = (mag_b > mag_a);
    sl     = swap ? sb : sa;
    ss     = swap ? sa : sb;
    el     = swap ? eb : ea;
    es     = swap ? ea : eb;
    sigl   = swap ? sigb : siga;
    sigs   = swap ? siga : sigb;
    diff   = el - es;
    // Clamping at SW keeps every shifted-out bit inside the low half for sticky.
    shamt   = (int'(diff) > SW) ? SW : int'(diff);
    shifted = {sigs, 3'b000, {SW{1'b0}}} >> shamt;
    aligned = {shifted[2*SW-1:SW+1], shifted[SW] | (|shifted[SW-1:0])};

    s1_spec = 1'b0;
    s1_inv  = 1'b0;
    s1_word = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      s1_spec = 1'b1;
      s1_inv  = 1'b1;
      s1_word = QNAN;
    end else if (a_inf || b_inf) begin
      s1_spec = 1'b1;
      s1_word = {a_inf ? sa : sb, EXP_MAX, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      s1_spec = 1'b1;
      s1_word = {sa & sb, {(W-1){1'b0}}};
    end
  end

  logic             v1, spec1, inv1, sign1, sub1;
  logic [W-1:0]     word1;
  logic [EXP_W-1:0] exp1;
  logic [SW-1:0]    ml1, ms1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; spec1 <= 1'b0; inv1 <= 1'b0; sign1 <= 1'b0; sub1 <= 1'b0;
      word1 <= '0; exp1 <= '0; ml1 <= '0; ms1 <= '0;
    end else if (advance) begin
      v1 <= take;
      if (take) begin
        spec1 <= s1_spec;
        inv1  <= s1_inv;
        word1 <= s1_word;
        sign1 <= sl;
        sub1  <= (sl != ss);
        exp1  <= el;
        ml1   <= {sigl, 3'b000};
        ms1   <= aligned;
      end
    end
  end

  // ---------------- S2: magnitude add/subtract ----------------
  logic             v2, spec2, inv2, sign2;
  logic [W-1:0]     word2;
  logic [EXP_W-1:0] exp2;
  logic [SW:0]      sum2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2 <= 1'b0; spec2 <= 1'b0; inv2 <= 1'b0; sign2 <= 1'b0;
      word2 <= '0; exp2 <= '0; sum2 <= '0;
    end else if (advance) begin
      v2 <= v1;
      if (v1) begin
        spec2 <= spec1;
        inv2  <= inv1;
        word2 <= word1;
        sign2 <= sign1;
        exp2  <= exp1;
        sum2  <= sub1 ? ({1'b0, ml1} - {1'b0, ms1}) : ({1'b0, ml1} + {1'b0, ms1});
      end
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [SW-1:0]          norm;
  logic signed [EW-1:0]   e_norm, e_fin;
  logic [MAN_W+1:0]       rnd;
  logic                   inc, ovf_c, inv_c;
  logic [W-1:0]           res;
  int                     lzc;

  always_comb begin
    lzc    = SW;
    for (int i = 0; i < SW; i++)
      if (sum2[i]) lzc = SW - 1 - i;
    norm   = sum2[SW-1:0];
    e_norm = EW'({2'b00, exp2});
    if (sum2[SW]) begin
      norm   = {sum2[SW:2], sum2[1] | sum2[0]};
      e_norm = e_norm + EW'(1);
    end else begin
      norm   = sum2[SW-1:0] << lzc;
      e_norm = e_norm - EW'(lzc);
    end
    inc   = norm[2] && (norm[1] || norm[0] || norm[3]);
    rnd   = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(inc);
    e_fin = e_norm + EW'(rnd[MAN_W+1]);

    res   = '0;
    ovf_c = 1'b0;
    inv_c = 1'b0;
    if (spec2) begin
      res   = word2;
      inv_c = inv2;
    end else if (sum2 == '0) begin
      res = '0;
    end else if (e_norm <= 0) begin
      res = {sign2, {(W-1){1'b0}}};
    end else if (e_fin >= E_INF) begin
      res   = {sign2, EXP_MAX, {MAN_W{1'b0}}};
      ovf_c = 1'b1;
    end else begin
      res = {sign2, e_fin[EXP_W-1:0], rnd[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.flag_ovf  <= 1'b0;
      bus.flag_inv  <= 1'b0;
      bus.flag_zero <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= v2;
      if (v2) begin
        bus.out       <= res;
        bus.flag_ovf  <= ovf_c;
        bus.flag_inv  <= inv_c;
        bus.flag_zero <= (res[W-2:0] == '0);
      end
    end
  end
endmodule

// File: tb/tb_fpadd_pipe.sv
// Self-checking bench for fpadd_pipe: vector table through a scoreboard,
// plus latency, output-stall and reset-flush sequences.
module tb_fpadd_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fpadd_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus();
  fpadd_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        ovf;
    logic        inv;
    logic        zero;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        inv;
    logic        zero;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int errors = 0;
  int checks = 0;
  int received = 0;
  int stall_cnt = 0;
  logic [31:0] ival [0:9];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                              input logic [31:0] res, input logic ovf, input logic inv,
                              input logic zero, input string name);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.res = res;
    v.ovf = ovf; v.inv = inv; v.zero = zero; v.name = name;
    return v;
  endfunction

  function automatic exp_t ex(input logic [31:0] res, input logic ovf, input logic inv,
                              input logic zero, input string name);
    exp_t e;
    e.res = res; e.ovf = ovf; e.inv = inv; e.zero = zero; e.name = name;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Output monitor: scoreboard pop on consume, hold check while stalled.
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out;
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {bus.out, bus.flag_ovf, bus.flag_inv, bus.flag_zero}, prev_out);
      if (bus.out_valid && !bus.out_ready) begin
        stall_cnt++;
        check("in_ready_low", bus.in_ready, 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got out=%h, expected no result", bus.out);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          received++;
          checks++;
          if ({bus.out, bus.flag_ovf, bus.flag_inv, bus.flag_zero} !== {e.res, e.ovf, e.inv, e.zero}) begin
            errors++;
            $display("FAIL %s: got out=%h ovf=%b inv=%b zero=%b, expected out=%h ovf=%b inv=%b zero=%b",
                     e.name, bus.out, bus.flag_ovf, bus.flag_inv, bus.flag_zero,
                     e.res, e.ovf, e.inv, e.zero);
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out, bus.flag_ovf, bus.flag_inv, bus.flag_zero};
    end
  end

  // Presents one operation and returns at posedge+1 after it is accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input exp_t e);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.reg_A = a;
    bus.reg_B = b;
    bus.op_sub = sub;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) sb_q.push_back(e);
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout_%s: got in_ready=0 for %0d cycles, expected acceptance", e.name, n);
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, sb_q.size(), 0);
  endtask

  task automatic latency_op(input string name, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int lat;
    send(a, b, 1'b0, e);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(name, lat, 3);
  endtask

  initial begin
    int r0;
    int stale;
    ival[0] = 32'h00000000; ival[1] = 32'h3F800000; ival[2] = 32'h40000000;
    ival[3] = 32'h40400000; ival[4] = 32'h40800000; ival[5] = 32'h40A00000;
    ival[6] = 32'h40C00000; ival[7] = 32'h40E00000; ival[8] = 32'h41000000;
    ival[9] = 32'h41100000;

    vecs.push_back(mk(32'h3F800000, 32'h3F800000, 0, 32'h40000000, 0, 0, 0, "one_plus_one"));
    vecs.push_back(mk(32'h3F800000, 32'h3F800000, 1, 32'h00000000, 0, 0, 1, "one_minus_one"));
    vecs.push_back(mk(32'h3F800000, 32'h33800000, 0, 32'h3F800000, 0, 0, 0, "tie_even_down"));
    vecs.push_back(mk(32'h3F800001, 32'h33800000, 0, 32'h3F800002, 0, 0, 0, "tie_even_up"));
    vecs.push_back(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 1, 0, 0, "max_overflow"));
    vecs.push_back(mk(32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 0, 1, 0, "inf_minus_inf"));
    vecs.push_back(mk(32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 0, 1, 0, "nan_in"));
    vecs.push_back(mk(32'h00000001, 32'h3F800000, 0, 32'h3F800000, 0, 0, 0, "denorm_flush"));
    vecs.push_back(mk(32'h80000000, 32'h80000000, 0, 32'h80000000, 0, 0, 1, "negz_plus_negz"));
    vecs.push_back(mk(32'hC0400000, 32'h40400000, 0, 32'h00000000, 0, 0, 1, "cancel_pos_zero"));
    vecs.push_back(mk(32'h40400000, 32'h3F800000, 1, 32'h40000000, 0, 0, 0, "three_minus_one"));
    vecs.push_back(mk(32'h3F800000, 32'h40400000, 1, 32'hC0000000, 0, 0, 0, "one_minus_three"));
    vecs.push_back(mk(32'h7F800000, 32'h3F800000, 0, 32'h7F800000, 0, 0, 0, "inf_plus_fin"));
    vecs.push_back(mk(32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 0, 1, 0, "inf_sub_inf"));
    vecs.push_back(mk(32'h00000000, 32'h80000000, 0, 32'h00000000, 0, 0, 1, "posz_plus_negz"));
    vecs.push_back(mk(32'h80000000, 32'h00000000, 1, 32'h80000000, 0, 0, 1, "negz_minus_posz"));
    vecs.push_back(mk(32'h3FC00000, 32'h3FC00000, 0, 32'h40400000, 0, 0, 0, "carry_norm"));
    vecs.push_back(mk(32'h40000000, 32'h3F800000, 0, 32'h40400000, 0, 0, 0, "two_plus_one"));
    vecs.push_back(mk(32'h3F800001, 32'h3F800000, 1, 32'h34000000, 0, 0, 0, "lzc_shift"));
    vecs.push_back(mk(32'h00800001, 32'h00800000, 1, 32'h00000000, 0, 0, 1, "underflow_flush"));
    vecs.push_back(mk(32'h3FFFFFFF, 32'h33800000, 0, 32'h40000000, 0, 0, 0, "round_mant_ovf"));
    vecs.push_back(mk(32'h7F7FFFFF, 32'h73000000, 0, 32'h7F800000, 1, 0, 0, "round_to_inf"));
    vecs.push_back(mk(32'hFFC00000, 32'h3F800000, 1, 32'h7FC00000, 0, 1, 0, "neg_nan_in"));

    bus.in_valid = 1'b0;
    bus.op_sub = 1'b0;
    bus.reg_A = '0;
    bus.reg_B = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {bus.out_valid, bus.out, bus.flag_ovf, bus.flag_inv, bus.flag_zero}, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 1);

    foreach (vecs[i])
      send(vecs[i].a, vecs[i].b, vecs[i].sub,
           ex(vecs[i].res, vecs[i].ovf, vecs[i].inv, vecs[i].zero, vecs[i].name));
    bus.in_valid = 1'b0;
    drain("table_drain");

    latency_op("latency", 32'h40000000, 32'h40000000, ex(32'h40800000, 0, 0, 0, "two_plus_two"));
    drain("latency_drain");

    // Eight back-to-back ops while the consumer stalls for five cycles.
    r0 = received;
    stall_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(ival[i+1], ival[1], 1'b0, ex(ival[i+2], 0, 0, 0, $sformatf("burst_%0d", i)));
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("burst_drain");
    check("burst_count", received - r0, 8);
    check("stall_cycles", stall_cnt, 5);

    // Reset with operations in flight.
    send(ival[1], ival[1], 1'b0, ex(ival[2], 0, 0, 0, "flushed_0"));
    send(ival[2], ival[1], 1'b0, ex(ival[3], 0, 0, 0, "flushed_1"));
    send(ival[3], ival[1], 1'b0, ex(ival[4], 0, 0, 0, "flushed_2"));
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    sb_q.delete();
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("no_stale_output", stale, 0);
    @(posedge clk);
    #1;
    latency_op("post_reset_latency", 32'h40400000, 32'h40400000, ex(32'h40C00000, 0, 0, 0, "three_plus_three"));
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
